// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up when the result is captured.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // CALC  | one shift-add / restoring-divide step per cycle
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int            CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [2:0]    OP_MUL    = 3'd0;
    localparam logic [2:0]    OP_MULH   = 3'd1;
    localparam logic [2:0]    OP_MULHSU = 3'd2;
    localparam logic [2:0]    OP_DIV    = 3'd4;
    localparam logic [2:0]    OP_REM    = 3'd6;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              negp_q, negp_d;
    logic              negr_q, negr_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    assign a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
    assign b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg = a_sgn & in_a[XLEN-1];
    assign b_neg = b_sgn & in_b[XLEN-1];
    assign mag_a = a_neg ? -in_a : in_a;
    assign mag_b = b_neg ? -in_b : in_b;
    assign div_zero = op[2] && (in_b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                      (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
    // op[1] separates REM/REMU from DIV/DIVU
    assign spec_res = div_zero ? (op[1] ? in_a : '1) : (op[1] ? '0 : in_a);

    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_nx, div_nx, step_nx, prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    // acc holds {partial product, multiplier} for MUL* and {remainder, quotient} for DIV*
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opb_q};
    assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_nx   = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign step_nx  = op_q[2] ? div_nx : mul_nx;
    assign prod     = negp_q ? -step_nx : step_nx;
    assign quo      = negp_q ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
    assign rem      = negr_q ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];
    assign fin_res  = !op_q[2] ? ((op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                               : (op_q[1] ? rem : quo);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        spec_d   = spec_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (!flush && in_valid) begin
                    op_d   = op;
                    acc_d  = {{XLEN{1'b0}}, mag_a};
                    opb_d  = mag_b;
                    negp_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    spec_d = div_zero || div_ovf;
                    if (div_zero || div_ovf) result_d = spec_res;
                    if ((div_zero || div_ovf) && EARLY_OUT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = step_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        if (!spec_q) result_d = fin_res;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            spec_q   <= spec_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit early-out instance and a 16-bit full-latency instance,
// directed corner cases plus random operations against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv32, iv16, ir32, ir16, ov32, ov16;
    logic        flush, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, r32;
    logic [15:0] r16;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op),
        .in_a(a), .in_b(b), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
        .result(r32));

    muldiv_unit #(.XLEN(16), .EARLY_OUT(1'b0)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
        .in_a(a[15:0]), .in_b(b[15:0]), .flush(flush), .out_valid(ov16), .out_ready(out_ready),
        .result(r16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic get_ov(input int w);
        return (w == 32) ? ov32 : ov16;
    endfunction

    function automatic logic [63:0] get_res(input int w);
        return (w == 32) ? {32'b0, r32} : {48'b0, r16};
    endfunction

    function automatic logic [63:0] ref_model(input int w, input logic [2:0] o,
                                              input logic [63:0] x, input logic [63:0] y);
        logic [63:0] m;
        logic [63:0] p;
        longint      sx, sy, q;
        bit          xs, ys;
        m  = (64'd1 << w) - 64'd1;
        xs = (o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        ys = (o inside {3'd0, 3'd1, 3'd4, 3'd6});
        sx = longint'(x & m);
        sy = longint'(y & m);
        if (xs && x[w-1]) sx = sx - longint'(64'd1 << w);
        if (ys && y[w-1]) sy = sy - longint'(64'd1 << w);
        if (!o[2]) begin
            p = 64'(sx * sy);
            return (o == 3'd0) ? (p & m) : ((p >> w) & m);
        end
        if ((y & m) == 64'd0) return o[1] ? (x & m) : m;
        if (ys && sx == -longint'(64'd1 << (w - 1)) && sy == -64'sd1)
            return o[1] ? 64'd0 : (x & m);
        q = o[1] ? (sx % sy) : (sx / sy);
        return 64'(q) & m;
    endfunction

    function automatic int exp_lat(input int w, input logic [2:0] o,
                                   input logic [63:0] x, input logic [63:0] y);
        logic [63:0] m;
        bit          special;
        m = (64'd1 << w) - 64'd1;
        special = o[2] && ((y == 64'd0) ||
                  ((o == 3'd4 || o == 3'd6) && x == (64'd1 << (w - 1)) && y == m));
        return (special && w == 32) ? 1 : w + 1;
    endfunction

    function automatic logic [63:0] rnd_opnd(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return m;
            3:       return 64'd1 << (w - 1);
            default: return {32'b0, $urandom} & m;
        endcase
    endfunction

    task automatic run_op(input int w, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, output logic [63:0] res, output int lat);
        @(negedge clk);
        op = o;
        a = x[31:0];
        b = y[31:0];
        out_ready = 1'b0;
        if (w == 32) iv32 = 1'b1;
        else iv16 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            iv32 = 1'b0;
            iv16 = 1'b0;
            lat++;
        end while (!get_ov(w) && lat < 200);
        res = get_res(w);
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic dir(input int w, input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp, input int elat,
                       input string tag);
        logic [63:0] res;
        int          lat;
        run_op(w, o, x, y, res, lat);
        check(tag, res, exp);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        pop();
    endtask

    initial begin
        logic [63:0] res, x, y;
        logic [2:0]  o;
        int          lat;
        logic        seen;

        rst_n = 1'b0; iv32 = 1'b0; iv16 = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_ir32", 64'(ir32), 64'd1);
        check("rst_ov32", 64'(ov32), 64'd0);
        check("rst_r32", 64'(r32), 64'd0);
        check("rst_ir16", 64'(ir16), 64'd1);
        check("rst_ov16", 64'(ov16), 64'd0);
        check("rst_r16", 64'(r16), 64'd0);
        rst_n = 1'b1;

        dir(32, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 33, "mul_ones");
        dir(32, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, "mulhu_ones");
        dir(32, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 33, "mulh_ones");
        dir(32, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, "mulhsu_ones");
        dir(32, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33, "div_m7");
        dir(32, 3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33, "rem_m7");
        dir(32, 3'd5, 64'hFFFFFFF9, 64'd2, 64'h7FFFFFFC, 33, "divu_m7");
        dir(32, 3'd7, 64'hFFFFFFF9, 64'd2, 64'h00000001, 33, "remu_m7");
        dir(32, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, "div_ovf");
        dir(32, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1, "rem_ovf");
        dir(32, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1, "divu_zero");
        dir(32, 3'd7, 64'd5, 64'd0, 64'd5, 1, "remu_zero");
        dir(16, 3'd4, 64'h8000, 64'hFFFF, 64'h8000, 17, "div_ovf_noeo");
        dir(16, 3'd6, 64'h8000, 64'hFFFF, 64'h0000, 17, "rem_ovf_noeo");
        dir(16, 3'd5, 64'd5, 64'd0, 64'hFFFF, 17, "divu_zero_noeo");
        dir(16, 3'd6, 64'hFFF9, 64'd0, 64'hFFF9, 17, "rem_zero_noeo");

        // backpressure: result held, new requests ignored while DONE
        run_op(32, 3'd0, 64'd3, 64'd5, res, lat);
        check("bp_first", res, 64'd15);
        op = 3'd4; a = 32'd100; b = 32'd7; iv32 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ov", 64'(ov32), 64'd1);
            check("bp_res", 64'(r32), 64'd15);
            check("bp_ir", 64'(ir32), 64'd0);
        end
        iv32 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel_ir", 64'(ir32), 64'd1);
        check("bp_rel_ov", 64'(ov32), 64'd0);

        // flush at CALC cycle 5, then flush racing an accept in IDLE
        @(negedge clk);
        op = 3'd0; a = 32'd7; b = 32'd9; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ir", 64'(ir32), 64'd1);
        check("flush_ov", 64'(ov32), 64'd0);
        op = 3'd0; a = 32'd2; b = 32'd2; iv32 = 1'b1; flush = 1'b1;
        @(negedge clk);
        iv32 = 1'b0; flush = 1'b0;
        check("flush_vs_accept_ir", 64'(ir32), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= ov32;
        end
        check("flush_no_ov", 64'(seen), 64'd0);
        dir(32, 3'd0, 64'd3, 64'd4, 64'd12, 33, "mul_after_flush");

        // flush while DONE with out_ready low
        run_op(16, 3'd3, 64'hFFFF, 64'hFFFF, res, lat);
        check("mulhu16", res, 64'hFFFE);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_ov", 64'(ov16), 64'd0);
        check("flush_done_ir", 64'(ir16), 64'd1);

        // one-cycle reset mid-CALC
        @(negedge clk);
        op = 3'd4; a = 32'd100; b = 32'd7; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstcalc_ir", 64'(ir16), 64'd1);
        check("rstcalc_ov", 64'(ov16), 64'd0);
        check("rstcalc_res", 64'(r16), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= ov16;
        end
        check("rstcalc_no_ov", 64'(seen), 64'd0);
        dir(16, 3'd4, 64'd100, 64'd7, 64'd14, 17, "div_after_rst");

        for (int i = 0; i < 600; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd_opnd(32);
            y = rnd_opnd(32);
            dir(32, o, x, y, ref_model(32, o, x, y), exp_lat(32, o, x, y),
                $sformatf("rand32 op%0d a=%0h b=%0h", o, x, y));
        end
        for (int i = 0; i < 600; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd_opnd(16);
            y = rnd_opnd(16);
            dir(16, o, x, y, ref_model(16, o, x, y), exp_lat(16, o, x, y),
                $sformatf("rand16 op%0d a=%0h b=%0h", o, x, y));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
